// File: rtl/reset_seq_ctrl.sv
// Reset-release sequencer: asserts NUM_OUT downstream resets on system
// reset, synchronises deassertion to clk, then releases them in order.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low system reset
//   sw_rst_req in   1-cycle request to re-assert all outputs and re-sequence
//   hold       in   freezes the gap counter while high
//   rst_out_n  out  active-low downstream resets, thermometer from bit 0
//   seq_done   out  high once every rst_out_n bit is released
//   stage      out  number of outputs released so far
module reset_seq_ctrl #(
  parameter int NUM_OUT     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int GAP_CYCLES  = 8,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sw_rst_req,
  input  logic               hold,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               seq_done,
  output logic [3:0]         stage
);

  localparam logic [1:0] S_SYNC = 2'd0;
  localparam logic [1:0] S_REL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       LAST   = 4'(NUM_OUT - 1);

  logic [1:0]             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_OUT-1:0]     rst_q, rst_d;
  logic [3:0]             stage_q, stage_d;
  logic                   done_q, done_d;

  always_comb begin
    state_d = state_q;
    sync_d  = sync_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    stage_d = stage_q;
    done_d  = done_q;
    unique case (state_q)
      S_SYNC: begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
        // Leave on the edge the chain output becomes 1.
        if (|sync_q[SYNC_STAGES-1:SYNC_STAGES-2]) begin
          state_d = S_REL;
          cnt_d   = '0;
        end
      end
      S_REL, S_DONE: begin
        if (sw_rst_req) begin
          state_d = S_REL;
          cnt_d   = '0;
          rst_d   = '0;
          stage_d = '0;
          done_d  = 1'b0;
        end else if (state_q == S_REL && !hold) begin
          if (cnt_q == GAP_M1) begin
            cnt_d   = '0;
            rst_d   = (rst_q << 1) | NUM_OUT'(1);
            stage_d = stage_q + 4'd1;
            if (stage_q == LAST) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_SYNC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_SYNC;
      sync_q  <= '0;
      cnt_q   <= '0;
      rst_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      stage_q <= stage_d;
      done_q  <= done_d;
    end
  end

  assign rst_out_n = rst_q;
  assign seq_done  = done_q;
  assign stage     = stage_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Testbench for reset_seq_ctrl: edge-counting reference model plus
// directed scenarios with literal release-edge expectations.
module tb_reset_seq_ctrl;

  localparam int N   = 4;
  localparam int S   = 2;
  localparam int GAP = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sw_rst_req = 1'b0;
  logic         hold = 1'b0;
  logic [N-1:0] rst_out_n;
  logic         seq_done;
  logic [3:0]   stage;

  int n_chk = 0;
  int n_fail = 0;

  // Model: edges since reset release, and unheld RELEASE edges
  // since the last (re)start; stage = min(N, eff / GAP).
  int ecount = 0;
  int eff = 0;

  reset_seq_ctrl #(
    .NUM_OUT(N), .SYNC_STAGES(S), .GAP_CYCLES(GAP), .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_rst_req(sw_rst_req),
    .hold(hold),
    .rst_out_n(rst_out_n),
    .seq_done(seq_done),
    .stage(stage)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ecount <= 0;
      eff <= 0;
    end else begin
      ecount <= ecount + 1;
      if (ecount + 1 > S) begin
        if (sw_rst_req) eff <= 0;
        else if (!hold) eff <= eff + 1;
      end
    end
  end

  function automatic int exp_stage();
    int s;
    s = eff / GAP;
    if (s > N) s = N;
    return s;
  endfunction

  always @(negedge clk) begin
    int es;
    logic [7:0] th;
    logic [7:0] dth;
    es = exp_stage();
    th = 8'((1 << es) - 1);
    dth = 8'((1 << stage) - 1);
    n_chk++;
    if (stage !== 4'(es)) begin
      n_fail++;
      $display("FAIL model_stage e=%0d got=%0d exp=%0d", ecount, stage, es);
    end
    n_chk++;
    if (rst_out_n !== th[N-1:0]) begin
      n_fail++;
      $display("FAIL model_rst e=%0d got=%b exp=%b", ecount, rst_out_n, th[N-1:0]);
    end
    n_chk++;
    if (seq_done !== (es == N)) begin
      n_fail++;
      $display("FAIL model_done e=%0d got=%b exp=%b", ecount, seq_done, es == N);
    end
    n_chk++;
    if (rst_out_n !== dth[N-1:0]) begin
      n_fail++;
      $display("FAIL thermo e=%0d rst=%b stage=%0d", ecount, rst_out_n, stage);
    end
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick_to(input int n);
    int k;
    k = 0;
    while (ecount < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (ecount != n) begin
      n_fail++;
      $display("FAIL tick_to got=%0d exp=%0d", ecount, n);
    end
  endtask

  task automatic look(input string nm, input int e, input logic [3:0] r,
                      input logic d, input logic [3:0] st);
    tick_to(e);
    chk({nm, "_rst"}, 8'(rst_out_n), 8'(r));
    chk({nm, "_done"}, 8'(seq_done), 8'(d));
    chk({nm, "_stage"}, 8'(stage), 8'(st));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Run 1: power-up with a request at edge 1 that must be ignored.
    do_reset();
    chk("por_rst", 8'(rst_out_n), 8'h0);
    chk("por_stage", 8'(stage), 8'h0);
    sw_rst_req = 1'b1;
    tick_to(1);
    sw_rst_req = 1'b0;
    look("r1e9", 9, 4'b0000, 1'b0, 4'd0);
    look("r1e10", 10, 4'b0001, 1'b0, 4'd1);
    look("r1e17", 17, 4'b0001, 1'b0, 4'd1);
    look("r1e18", 18, 4'b0011, 1'b0, 4'd2);
    look("r1e26", 26, 4'b0111, 1'b0, 4'd3);
    look("r1e33", 33, 4'b0111, 1'b0, 4'd3);
    look("r1e34", 34, 4'b1111, 1'b1, 4'd4);

    // Asynchronous reset mid-cycle while DONE.
    tick_to(36);
    #2 reset = 1'b0;
    #1;
    chk("async_rst", 8'(rst_out_n), 8'h0);
    chk("async_done", 8'(seq_done), 8'h0);
    chk("async_stage", 8'(stage), 8'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Run 2: hold over edges 12..15, then restart at edge 40.
    tick_to(11);
    hold = 1'b1;
    tick_to(15);
    hold = 1'b0;
    look("r2e21", 21, 4'b0001, 1'b0, 4'd1);
    look("r2e22", 22, 4'b0011, 1'b0, 4'd2);
    look("r2e30", 30, 4'b0111, 1'b0, 4'd3);
    look("r2e37", 37, 4'b0111, 1'b0, 4'd3);
    look("r2e38", 38, 4'b1111, 1'b1, 4'd4);
    tick_to(39);
    sw_rst_req = 1'b1;
    tick_to(40);
    sw_rst_req = 1'b0;
    chk("sw40_rst", 8'(rst_out_n), 8'h0);
    chk("sw40_done", 8'(seq_done), 8'h0);
    look("r2e47", 47, 4'b0000, 1'b0, 4'd0);
    look("r2e48", 48, 4'b0001, 1'b0, 4'd1);
    look("r2e64", 64, 4'b0111, 1'b0, 4'd3);
    look("r2e72", 72, 4'b1111, 1'b1, 4'd4);

    // Run 3: restart on the same edge as a release, with hold also high.
    do_reset();
    tick_to(17);
    sw_rst_req = 1'b1;
    hold = 1'b1;
    tick_to(18);
    sw_rst_req = 1'b0;
    hold = 1'b0;
    chk("sw18_rst", 8'(rst_out_n), 8'h0);
    chk("sw18_stage", 8'(stage), 8'h0);
    look("r3e25", 25, 4'b0000, 1'b0, 4'd0);
    look("r3e26", 26, 4'b0001, 1'b0, 4'd1);
    look("r3e50", 50, 4'b1111, 1'b1, 4'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
